// File: rtl/add_sub_accumulator_pkg.sv
// Shared definitions for the add/subtract accumulator: op codes, flag bit
// positions and the output-register FSM states.
package add_sub_accumulator_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_ADC  = 3'd2,
    OP_SUB  = 3'd3,
    OP_SBC  = 3'd4,
    OP_CMP  = 3'd5,
    OP_CLR  = 3'd6,
    OP_NOP  = 3'd7
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int FLAGS_W = 5;
  localparam int FLAG_V  = 0;
  localparam int FLAG_C  = 1;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_N  = 3;
  localparam int FLAG_VS = 4;

  function automatic logic [FLAGS_W-1:0] pack_flags(input logic vs, input logic n,
                                                    input logic z, input logic c,
                                                    input logic v);
    pack_flags = {vs, n, z, c, v};
  endfunction

endpackage

// File: rtl/add_sub_accumulator_if.sv
// Request/response bundle between an operation source and the accumulator.
interface add_sub_accumulator_if
  import add_sub_accumulator_pkg::*;
#(
  parameter int M = 32
) ();

  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_op;
  logic [M-1:0]       in_operand;
  logic               out_valid;
  logic               out_ready;
  logic [M-1:0]       out_acc;
  logic [FLAGS_W-1:0] out_flags;

  modport master (
    output in_valid, in_op, in_operand, out_ready,
    input  in_ready, out_valid, out_acc, out_flags
  );

  modport slave (
    input  in_valid, in_op, in_operand, out_ready,
    output in_ready, out_valid, out_acc, out_flags
  );

endinterface

// File: rtl/acc_addsub_core.sv
// Combinational carry-select add/subtract: sum = x + (y ^ {M{sub}}) + cin,
// built from R-bit blocks that each precompute both carry-in outcomes.
module acc_addsub_core #(
  parameter int M = 32,
  parameter int R = 4
) (
  input  logic [M-1:0] x,
  input  logic [M-1:0] y,
  input  logic         sub,
  input  logic         cin,
  output logic [M-1:0] sum,
  output logic         cout,
  output logic         v
);

  localparam int NB = M / R;

  logic [M-1:0] b;
  logic [NB:0]  c;

  assign b    = y ^ {M{sub}};
  assign c[0] = cin;

  for (genvar i = 0; i < NB; i++) begin : g_blk
    logic [R:0] s0;
    logic [R:0] s1;

    assign s0 = {1'b0, x[i*R +: R]} + {1'b0, b[i*R +: R]};
    assign s1 = {1'b0, x[i*R +: R]} + {1'b0, b[i*R +: R]} + {{R{1'b0}}, 1'b1};

    assign sum[i*R +: R] = c[i] ? s1[R-1:0] : s0[R-1:0];
    assign c[i+1]        = c[i] ? s1[R]     : s0[R];
  end

  assign cout = c[NB];
  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  assign v    = (x[M-1] ^ b[M-1] ^ sum[M-1]) ^ cout;

endmodule

// File: rtl/add_sub_accumulator.sv
// Accumulator with a single registered output beat, carry chaining for
// multi-word arithmetic and a sticky signed-overflow flag.
module add_sub_accumulator
  import add_sub_accumulator_pkg::*;
#(
  parameter int M = 32,
  parameter int R = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  add_sub_accumulator_if.slave bus
);

  state_e             state_q, state_d;
  logic [M-1:0]       acc_q, acc_d;
  logic [FLAGS_W-1:0] flags_q, flags_d;

  op_e          op;
  logic         core_sub;
  logic         core_cin;
  logic [M-1:0] core_sum;
  logic         core_cout;
  logic         core_v;
  logic         out_valid;
  logic         in_ready;
  logic         in_xfer;
  logic         out_xfer;
  logic [FLAGS_W-1:0] arith_flags;

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || bus.out_ready;
  assign in_xfer   = bus.in_valid && in_ready;
  assign out_xfer  = out_valid && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_acc   = acc_q;
  assign bus.out_flags = flags_q;

  acc_addsub_core #(
    .M (M),
    .R (R)
  ) u_core (
    .x    (acc_q),
    .y    (bus.in_operand),
    .sub  (core_sub),
    .cin  (core_cin),
    .sum  (core_sum),
    .cout (core_cout),
    .v    (core_v)
  );

  // Carry-in comes straight from the stored C so chained ops never stall.
  always_comb begin
    op       = op_e'(bus.in_op);
    core_sub = 1'b0;
    core_cin = 1'b0;
    case (op)
      OP_ADC: core_cin = flags_q[FLAG_C];
      OP_SUB,
      OP_CMP: begin
        core_sub = 1'b1;
        core_cin = 1'b1;
      end
      OP_SBC: begin
        core_sub = 1'b1;
        core_cin = flags_q[FLAG_C];
      end
      default: ;
    endcase
  end

  assign arith_flags = pack_flags(flags_q[FLAG_VS] | core_v, core_sum[M-1],
                                  (core_sum == '0), core_cout, core_v);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    flags_d = flags_q;

    case (state_q)
      ST_EMPTY: if (in_xfer) state_d = ST_FULL;
      ST_FULL:  if (out_xfer && !in_xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (in_xfer) begin
      case (op)
        OP_LOAD: begin
          acc_d   = bus.in_operand;
          flags_d = pack_flags(flags_q[FLAG_VS], bus.in_operand[M-1],
                               (bus.in_operand == '0), 1'b0, 1'b0);
        end
        OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
          acc_d   = core_sum;
          flags_d = arith_flags;
        end
        OP_CMP: flags_d = arith_flags;
        OP_CLR: begin
          acc_d   = '0;
          flags_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: doc/add_sub_accumulator.md
ADD_SUB_ACCUMULATOR -- requirements
Module: add_sub_accumulator

Interface
REQ-001 Parameter M, default 32, datapath width in bits.
REQ-002 Parameter R, default 4, carry-select block width; M SHALL be a multiple of R and M > R.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  accumulator can accept an operation this cycle.
REQ-007 in_op  input  3  operation code; encodings in package (REQ-016).
REQ-008 in_operand  input  M  operand y.
REQ-009 out_valid  output  1  result/flags valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 out_acc  output  M  accumulator value.
REQ-012 out_flags  output  5  {VS, N, Z, C, V}: sticky overflow, negative, zero, carry (1 = no borrow on subtract), signed overflow.

Function
REQ-013 Transfer on input when in_valid & in_ready; on output when out_valid & out_ready.
REQ-014 in_ready SHALL equal !out_valid | out_ready (single output register, no combinational path from in_valid to in_ready).
REQ-015 FSM: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on input transfer; FULL->EMPTY on output transfer without input transfer; FULL->FULL on simultaneous input and output transfer (new result replaces old in the same edge).
REQ-016 Ops, result = acc + (y ^ {M{sub}}) + cin_eff: LOAD (acc<=y, C,V<=0), ADD (sub=0, cin=0), ADC (sub=0, cin=C), SUB (sub=1, cin=1), SBC (sub=1, cin=C), CMP (as SUB, flags only, acc unchanged), CLR (acc<=0, all five flags <=0), NOP (no change, still produces one output beat).
REQ-017 Latency: one cycle; result of an op accepted at edge k is on out_acc/out_flags with out_valid=1 after edge k.
REQ-018 C = adder carry-out of bit M-1; V = carry into MSB XOR carry out of MSB; N = result[M-1]; Z = (result == 0); for LOAD, N and Z from y.
REQ-019 VS SHALL be set by any ADD/ADC/SUB/SBC/CMP producing V=1 and cleared only by CLR or reset.
REQ-020 ADC/SBC SHALL use C as stored at the accept edge, including C produced by the immediately preceding op (no stall).
REQ-021 Out_acc and out_flags SHALL hold stable while out_valid & !out_ready.
REQ-022 Undefined in_op codes SHALL behave as NOP.
REQ-023 Arithmetic is modulo 2^M; no saturation.

Reset
REQ-024 On rst_n low, asynchronously: out_valid=0, out_acc=0, out_flags=0, FSM=EMPTY; in_ready=1 one cycle after deassertion.
REQ-025 Reset asserted mid-transfer SHALL discard the pending result; no output beat after release until a new input transfer.

Structure
REQ-026 Shared package: op-code enum (LOAD, ADD, ADC, SUB, SBC, CMP, CLR, NOP), flag-bit index constants, FSM state enum.
REQ-027 One sub-module, acc_addsub_core: combinational carry-select adder (parameters M, R) with inputs x, y, sub, cin, outputs sum, cout, v; all registers in add_sub_accumulator.
REQ-028 No latches; single always_ff for state, accumulator, flags.

Verification
REQ-029 Reset, idle: out_valid=0, out_acc=0, out_flags=0, in_ready=1.
REQ-030 LOAD 0x7FFFFFFF, ADD 0x00000001 -> out_acc=0x80000000, N=1, V=1, VS=1, C=0, Z=0; then SUB 0x80000000 -> 0x00000000, Z=1, C=1, V=0, VS still 1.
REQ-031 64-bit chain: LOAD 0xFFFFFFFF, ADD 0x00000001 -> 0, C=1; ADC 0x00000000 back-to-back -> 0x00000001, C=0; LOAD 0, SBC 0 with C=0 -> 0xFFFFFFFF, C=0, N=1.
REQ-032 CMP: LOAD 5, CMP 7 -> out_acc=5, C=0, N=1, Z=0; CLR -> acc 0, flags 0.
REQ-033 Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, op not consumed; out_ready=1 -> simultaneous transfer, new result next cycle.
REQ-034 Reset asserted while FULL with out_ready=0 -> out_valid drops immediately, acc=0, no stale beat after release.
